// File: rtl/alu_result_skid.sv
// rtl/alu_result_skid.sv - registered ALU result stage with 2-entry skid buffer, flags, tag and transfer counter
module alu_result_skid #(
    parameter int W     = 32,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_y,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_par,
    output logic [CNT_W-1:0] xfer_cnt
);

    // Entry layout: {tag, par, neg, zero, y}
    localparam int E_W = W + TAG_W + 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [E_W-1:0] main_q;
    logic [E_W-1:0] skid_q;
    logic [E_W-1:0] in_entry;
    logic           in_ready_q;
    logic           acc_in;
    logic           acc_out;

    // Flags are derived once at capture and travel with the word.
    assign in_entry = {in_tag, ^in_y, in_y[W-1], (in_y == '0), in_y};

    assign out_valid = (state != EMPTY);
    assign in_ready  = in_ready_q;
    assign acc_in    = in_valid & in_ready_q;
    assign acc_out   = out_valid & out_ready;

    assign out_y    = main_q[W-1:0];
    assign out_zero = main_q[W];
    assign out_neg  = main_q[W+1];
    assign out_par  = main_q[W+2];
    assign out_tag  = main_q[E_W-1 -: TAG_W];

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (acc_in) state_nxt = BUSY;
            BUSY: begin
                if (acc_in && !acc_out)      state_nxt = FULL;
                else if (!acc_in && acc_out) state_nxt = EMPTY;
            end
            FULL:    if (acc_out) state_nxt = BUSY;
            default: state_nxt = EMPTY;
        endcase
    end

    // in_ready is a flop loaded from the next state, so out_ready never reaches it combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
            xfer_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != FULL);
            if (acc_in) xfer_cnt <= xfer_cnt + CNT_W'(1);
            case (state)
                EMPTY: if (acc_in) main_q <= in_entry;
                BUSY: begin
                    if (acc_in && acc_out) main_q <= in_entry;
                    else if (acc_in)       skid_q <= in_entry;
                end
                FULL:    if (acc_out) main_q <= skid_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_skid.sv
// tb/tb_alu_result_skid.sv - directed self-checking bench for alu_result_skid
module tb_alu_result_skid;

    localparam int W     = 32;
    localparam int TAG_W = 4;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_y;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_y;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;
    logic             out_neg;
    logic             out_par;
    logic [CNT_W-1:0] xfer_cnt;

    int checks = 0;
    int errors = 0;

    alu_result_skid #(.W(W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_y      (in_y),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_tag   (out_tag),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_par   (out_par),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_y = '0; in_tag = '0;
        #2;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready act=%b req=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid act=%b req=0", out_valid); end
        step();
        rst = 1'b0;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready act=%b req=1", in_ready); end
        // Fill to FULL, then hit reset between edges.
        in_valid = 1'b1; in_y = 32'h55; in_tag = 4'd1; step();
        in_y = 32'h66; in_tag = 4'd2; step();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL prefull_in_ready act=%b req=0", in_ready); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midfull_out_valid act=%b req=0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midfull_in_ready act=%b req=0", in_ready); end
        checks++; if (xfer_cnt !== 4'd0) begin errors++; $display("FAIL midfull_xfer_cnt act=%0d req=0", xfer_cnt); end
        checks++; if (out_y !== 32'h0) begin errors++; $display("FAIL midfull_out_y act=%h req=0", out_y); end
        step();
        rst = 1'b0;
        step();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL after_reset act_rdy=%b act_vld=%b req=1/0", in_ready, out_valid); end
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 1'b0; in_y = 'x; in_tag = 'x;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL x_idle_out_valid act=%b req=0", out_valid); end
        in_valid = 1'b1; in_y = 32'h0000_0000; in_tag = 4'd3;
        step();
        in_valid = 1'b0; in_y = 'x; in_tag = 'x;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid act=%b req=1", out_valid); end
        checks++; if ({out_zero, out_neg, out_par} !== 3'b100) begin errors++; $display("FAIL single_flags act=%b req=100", {out_zero, out_neg, out_par}); end
        checks++; if (out_tag !== 4'd3 || out_y !== 32'h0) begin errors++; $display("FAIL single_data act=%h/%h req=3/0", out_tag, out_y); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain act=%b req=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_stream();
        logic [7:0] par_tab;
        par_tab = 8'h34;
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_y = 32'h8000_0000 | i; in_tag = 4'(i);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_y !== (32'h8000_0000 | i) || out_tag !== 4'(i)
                || out_neg !== 1'b1 || out_zero !== 1'b0 || out_par !== par_tab[i-1] || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_%0d act=v%b y%h t%h n%b z%b p%b r%b req=v1 y%h t%h n1 z0 p%b r1",
                         i, out_valid, out_y, out_tag, out_neg, out_zero, out_par, in_ready,
                         32'h8000_0000 | i, 4'(i), par_tab[i-1]);
            end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain act=%b req=0", out_valid); end
        checks++; if (xfer_cnt !== 4'd8) begin errors++; $display("FAIL stream_cnt act=%0d req=8", xfer_cnt); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid = 1'b1; in_y = 32'h1; in_tag = 4'hA;
        step();
        checks++; if (out_y !== 32'h1 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_a act=%h/%b req=1/1", out_y, in_ready); end
        in_y = 32'h3; in_tag = 4'hB;
        step();
        checks++; if (in_ready !== 1'b0 || out_y !== 32'h1 || out_par !== 1'b1) begin errors++; $display("FAIL bp_full act=%b/%h/%b req=0/1/1", in_ready, out_y, out_par); end
        in_y = 32'hFF; in_tag = 4'hC;
        step();
        checks++; if (out_y !== 32'h1 || out_tag !== 4'hA || xfer_cnt !== 4'd2) begin errors++; $display("FAIL bp_hold act=%h/%h/%0d req=1/a/2", out_y, out_tag, xfer_cnt); end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        checks++; if (out_y !== 32'h3 || out_tag !== 4'hB || out_par !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_b act=%h/%h/%b req=3/b/0", out_y, out_tag, out_par); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready act=%b req=1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty act=%b req=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_valid = 1'b1; in_y = 32'h10; in_tag = 4'd0;
        step();
        out_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            in_y = 32'h10 + i; in_tag = 4'(i);
            step();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_y !== 32'h10 + i || out_tag !== 4'(i)) begin
                errors++;
                $display("FAIL b2b_%0d act=v%b r%b y%h t%h req=v1 r1 y%h t%h", i, out_valid, in_ready, out_y, out_tag, 32'h10 + i, 4'(i));
            end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || xfer_cnt !== 4'd7) begin errors++; $display("FAIL b2b_end act=%b/%0d req=0/7", out_valid, xfer_cnt); end
        out_ready = 1'b0;
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_y = 32'h7; in_tag = 4'd0;
        for (int i = 0; i < 15; i++) step();
        checks++; if (xfer_cnt !== 4'd15) begin errors++; $display("FAIL cnt_15 act=%0d req=15", xfer_cnt); end
        step();
        checks++; if (xfer_cnt !== 4'd0) begin errors++; $display("FAIL cnt_wrap act=%0d req=0", xfer_cnt); end
        step();
        in_valid = 1'b0;
        checks++; if (xfer_cnt !== 4'd1) begin errors++; $display("FAIL cnt_after act=%0d req=1", xfer_cnt); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_cnt_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
